// File: rtl/v_wb_buffer.sv
// Write-back buffer between a fixed-latency ALU pipeline and the register-file write port.
// Tracks in-flight operations so issue is throttled before the FIFO could ever overflow.
module v_wb_buffer #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned INFLIGHT_MAX = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     issue_valid,
   output logic                     can_issue,
   input  logic                     in_valid,
   input  logic [ADDR_WIDTH-1:0]    in_addr,
   input  logic [DATA_WIDTH-1:0]    in_vec,
   output logic                     wb_valid,
   input  logic                     wb_ready,
   output logic [ADDR_WIDTH-1:0]    wb_addr,
   output logic [DATA_WIDTH-1:0]    wb_data,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     err_overflow,
   output logic                     err_unexpected
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned INF_W = $clog2(INFLIGHT_MAX + 1);

   logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic [INF_W-1:0] inflight_q, inflight_d;
   logic             err_overflow_q, err_overflow_d;
   logic             err_unexpected_q, err_unexpected_d;

   logic full;
   logic push;
   logic pop;
   logic overflow;
   logic unexpected;

   // Push/pop decode, pointer/occupancy/credit next state and sticky error updates.
   always_comb begin
      full       = (occ_q == OCC_W'(DEPTH));
      wb_valid   = (occ_q != '0);
      pop        = wb_valid && wb_ready;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push       = in_valid && (!full || pop);
      overflow   = in_valid && full && !pop;
      unexpected = in_valid && !issue_valid && (inflight_q == '0);

      head_d = pop  ? head_q + PTR_W'(1) : head_q;
      tail_d = push ? tail_q + PTR_W'(1) : tail_q;

      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase

      inflight_d = inflight_q;
      if (issue_valid && !in_valid) begin
         // Over-issue is a protocol violation; saturate rather than wrap.
         if (inflight_q < INF_W'(INFLIGHT_MAX)) inflight_d = inflight_q + INF_W'(1);
      end else if (in_valid && !issue_valid) begin
         if (inflight_q != '0) inflight_d = inflight_q - INF_W'(1);
      end

      err_overflow_d   = err_overflow_q || overflow;
      err_unexpected_d = err_unexpected_q || unexpected;
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q           <= '0;
         tail_q           <= '0;
         occ_q            <= '0;
         inflight_q       <= '0;
         err_overflow_q   <= 1'b0;
         err_unexpected_q <= 1'b0;
      end else begin
         head_q           <= head_d;
         tail_q           <= tail_d;
         occ_q            <= occ_d;
         inflight_q       <= inflight_d;
         err_overflow_q   <= err_overflow_d;
         err_unexpected_q <= err_unexpected_d;
      end
   end

   // Entry storage; cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            addr_mem_q[i] <= '0;
            data_mem_q[i] <= '0;
         end
      end else if (push) begin
         addr_mem_q[tail_q] <= in_addr;
         data_mem_q[tail_q] <= in_vec;
      end
   end

   // Outputs derived from registered state only (no fall-through).
   always_comb begin
      wb_addr        = addr_mem_q[head_q];
      wb_data        = data_mem_q[head_q];
      occupancy      = occ_q;
      err_overflow   = err_overflow_q;
      err_unexpected = err_unexpected_q;
      can_issue      = ((32'(occ_q) + 32'(inflight_q)) < DEPTH)
                       && (inflight_q < INF_W'(INFLIGHT_MAX));
   end

endmodule

// File: tb/tb_v_wb_buffer.sv
// Directed bench for v_wb_buffer with default parameters (DEPTH=8, INFLIGHT_MAX=15).
module tb_v_wb_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic        can_issue;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [63:0] in_vec;
   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_addr;
   logic [63:0] wb_data;
   logic [3:0]  occupancy;
   logic        err_overflow;
   logic        err_unexpected;

   int checks   = 0;
   int failures = 0;

   v_wb_buffer dut (
      .clk            (clk),
      .rst            (rst),
      .issue_valid    (issue_valid),
      .can_issue      (can_issue),
      .in_valid       (in_valid),
      .in_addr        (in_addr),
      .in_vec         (in_vec),
      .wb_valid       (wb_valid),
      .wb_ready       (wb_ready),
      .wb_addr        (wb_addr),
      .wb_data        (wb_data),
      .occupancy      (occupancy),
      .err_overflow   (err_overflow),
      .err_unexpected (err_unexpected)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; issue_valid = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
      in_addr = '0; in_vec = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (occupancy !== 4'd0) begin failures++;
         $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      checks++; if (wb_valid !== 1'b0) begin failures++;
         $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
      checks++; if (can_issue !== 1'b1) begin failures++;
         $display("FAIL reset_can_issue got=%b exp=1", can_issue); end
      checks++; if ({err_overflow, err_unexpected} !== 2'b00) begin failures++;
         $display("FAIL reset_errs got=%b%b exp=00", err_overflow, err_unexpected); end
      checks++; if (wb_addr !== 32'd0 || wb_data !== 64'd0) begin failures++;
         $display("FAIL reset_wb_zero got=%h/%h exp=0/0", wb_addr, wb_data); end
   endtask

   task automatic test_latency();
      do_reset();
      wb_ready = 1'b1;
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      for (int c = 1; c < 6; c++) begin
         checks++; if (can_issue !== 1'b1 || wb_valid !== 1'b0) begin failures++;
            $display("FAIL lat_wait c=%0d got can=%b v=%b exp can=1 v=0", c, can_issue, wb_valid); end
         tick();
      end
      in_valid = 1'b1; in_addr = 32'h10; in_vec = 64'hA5A5_A5A5_A5A5_A5A5;
      checks++; if (wb_valid !== 1'b0) begin failures++;
         $display("FAIL lat_no_fallthrough got=%b exp=0", wb_valid); end
      tick();
      in_valid = 1'b0;
      checks++; if (wb_valid !== 1'b1 || wb_addr !== 32'h10 || wb_data !== 64'hA5A5_A5A5_A5A5_A5A5)
      begin failures++;
         $display("FAIL lat_c7 got v=%b a=%h d=%h exp v=1 a=10 d=a5a5a5a5a5a5a5a5",
                  wb_valid, wb_addr, wb_data); end
      checks++; if (can_issue !== 1'b1) begin failures++;
         $display("FAIL lat_c7_can got=%b exp=1", can_issue); end
      tick();
      checks++; if (occupancy !== 4'd0 || wb_valid !== 1'b0) begin failures++;
         $display("FAIL lat_c8 got occ=%0d v=%b exp occ=0 v=0", occupancy, wb_valid); end
      checks++; if (err_unexpected !== 1'b0) begin failures++;
         $display("FAIL lat_unexp got=%b exp=0", err_unexpected); end
   endtask

   // Issue while allowed; results return 6 cycles later with no pops.
   task automatic test_fill();
      bit hist [0:31];
      int grants = 0;
      int rcount = 0;
      do_reset();
      for (int c = 0; c < 32; c++) hist[c] = 1'b0;
      for (int c = 0; c < 20; c++) begin
         issue_valid = can_issue;
         if (can_issue) begin grants++; hist[c] = 1'b1; end
         in_valid = (c >= 6) && hist[c-6];
         in_addr = 32'h100 + 32'(rcount);
         in_vec  = 64'hD000_0000_0000_0000 | 64'(rcount);
         if (in_valid) rcount++;
         tick();
      end
      issue_valid = 1'b0; in_valid = 1'b0;
      checks++; if (grants !== 8) begin failures++;
         $display("FAIL fill_grants got=%0d exp=8", grants); end
      checks++; if (occupancy !== 4'd8 || can_issue !== 1'b0) begin failures++;
         $display("FAIL fill_state got occ=%0d can=%b exp occ=8 can=0", occupancy, can_issue); end
      checks++; if (err_overflow !== 1'b0 || wb_addr !== 32'h100) begin failures++;
         $display("FAIL fill_head got ovf=%b a=%h exp ovf=0 a=100", err_overflow, wb_addr); end
   endtask

   // Continues from the full FIFO left by test_fill.
   task automatic test_full_push_pop();
      logic [31:0] exp_a;
      logic [63:0] exp_d;
      wb_ready = 1'b1; in_valid = 1'b1; issue_valid = 1'b1;
      in_addr = 32'h200; in_vec = 64'h2000;
      checks++; if (wb_addr !== 32'h100) begin failures++;
         $display("FAIL fpp_head got=%h exp=100", wb_addr); end
      tick();
      in_valid = 1'b0; issue_valid = 1'b0;
      checks++; if (occupancy !== 4'd8) begin failures++;
         $display("FAIL fpp_occ got=%0d exp=8", occupancy); end
      for (int i = 0; i < 8; i++) begin
         exp_a = (i < 7) ? 32'h101 + 32'(i) : 32'h200;
         exp_d = (i < 7) ? (64'hD000_0000_0000_0001 + 64'(i)) : 64'h2000;
         checks++; if (wb_valid !== 1'b1 || wb_addr !== exp_a || wb_data !== exp_d) begin
            failures++;
            $display("FAIL fpp_drain i=%0d got a=%h d=%h exp a=%h d=%h",
                     i, wb_addr, wb_data, exp_a, exp_d); end
         tick();
      end
      checks++; if (occupancy !== 4'd0 || err_overflow !== 1'b0 || err_unexpected !== 1'b0)
      begin failures++;
         $display("FAIL fpp_end got occ=%0d ovf=%b unx=%b exp 0/0/0",
                  occupancy, err_overflow, err_unexpected); end
   endtask

   task automatic test_overflow();
      do_reset();
      issue_valid = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_addr = 32'h300 + 32'(i); in_vec = 64'h3000 + 64'(i);
         tick();
      end
      in_addr = 32'h3FF; in_vec = 64'h3FFF;
      checks++; if (err_overflow !== 1'b0) begin failures++;
         $display("FAIL ovf_pre got=%b exp=0", err_overflow); end
      tick();
      issue_valid = 1'b0; in_valid = 1'b0;
      checks++; if (err_overflow !== 1'b1 || occupancy !== 4'd8 || wb_addr !== 32'h300) begin
         failures++;
         $display("FAIL ovf_set got ovf=%b occ=%0d a=%h exp 1/8/300",
                  err_overflow, occupancy, wb_addr); end
      repeat (3) tick();
      checks++; if (err_overflow !== 1'b1) begin failures++;
         $display("FAIL ovf_sticky got=%b exp=1", err_overflow); end
      wb_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (wb_addr !== 32'h300 + 32'(i) || wb_data !== 64'h3000 + 64'(i)) begin
            failures++;
            $display("FAIL ovf_contents i=%0d got a=%h d=%h exp a=%h d=%h",
                     i, wb_addr, wb_data, 32'h300 + 32'(i), 64'h3000 + 64'(i)); end
         tick();
      end
      checks++; if (occupancy !== 4'd0 || err_overflow !== 1'b1) begin failures++;
         $display("FAIL ovf_after got occ=%0d ovf=%b exp 0/1", occupancy, err_overflow); end
      do_reset();
      checks++; if (err_overflow !== 1'b0) begin failures++;
         $display("FAIL ovf_clear got=%b exp=0", err_overflow); end
   endtask

   task automatic test_unexpected();
      do_reset();
      in_valid = 1'b1; in_addr = 32'h400; in_vec = 64'h4444;
      tick();
      in_valid = 1'b0;
      checks++; if (err_unexpected !== 1'b1 || occupancy !== 4'd1 || wb_addr !== 32'h400
                    || wb_data !== 64'h4444) begin failures++;
         $display("FAIL unx_set got unx=%b occ=%0d a=%h d=%h exp 1/1/400/4444",
                  err_unexpected, occupancy, wb_addr, wb_data); end
      // inflight must still be 0: 1 queued + 7 issues is the first point can_issue drops.
      issue_valid = 1'b1;
      repeat (6) tick();
      checks++; if (can_issue !== 1'b1) begin failures++;
         $display("FAIL unx_inflight6 got=%b exp=1", can_issue); end
      tick();
      issue_valid = 1'b0;
      checks++; if (can_issue !== 1'b0) begin failures++;
         $display("FAIL unx_inflight7 got=%b exp=0", can_issue); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      issue_valid = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_addr = 32'h500 + 32'(i); in_vec = 64'h5000 + 64'(i);
         tick();
      end
      in_valid = 1'b0;
      repeat (3) tick();
      issue_valid = 1'b0;
      checks++; if (occupancy !== 4'd5 || can_issue !== 1'b0) begin failures++;
         $display("FAIL mrst_pre got occ=%0d can=%b exp 5/0", occupancy, can_issue); end
      rst = 1'b1; issue_valid = 1'b1; in_valid = 1'b1; wb_ready = 1'b1;
      tick();
      rst = 1'b0; issue_valid = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
      checks++; if (occupancy !== 4'd0 || wb_valid !== 1'b0 || can_issue !== 1'b1
                    || wb_addr !== 32'd0) begin failures++;
         $display("FAIL mrst_post got occ=%0d v=%b can=%b a=%h exp 0/0/1/0",
                  occupancy, wb_valid, can_issue, wb_addr); end
      in_valid = 1'b1; in_addr = 32'h5FF;
      tick();
      in_valid = 1'b0;
      checks++; if (err_unexpected !== 1'b1 || occupancy !== 4'd1) begin failures++;
         $display("FAIL mrst_late got unx=%b occ=%0d exp 1/1", err_unexpected, occupancy); end
   endtask

   task automatic test_inflight_saturate();
      do_reset();
      issue_valid = 1'b1;
      repeat (20) tick();
      issue_valid = 1'b0;
      checks++; if (can_issue !== 1'b0) begin failures++;
         $display("FAIL sat_can got=%b exp=0", can_issue); end
      wb_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_addr = 32'h600 + 32'(i);
         tick();
      end
      checks++; if (err_unexpected !== 1'b0 || err_overflow !== 1'b0) begin failures++;
         $display("FAIL sat_15 got unx=%b ovf=%b exp 0/0", err_unexpected, err_overflow); end
      tick();
      in_valid = 1'b0;
      checks++; if (err_unexpected !== 1'b1) begin failures++;
         $display("FAIL sat_16 got=%b exp=1", err_unexpected); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_fill();
      test_full_push_pop();
      test_overflow();
      test_unexpected();
      test_mid_reset();
      test_inflight_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
